// File: rtl/matinv2_if.sv
// Handshake bundle for the 2x2 inverse block: matrix in, inverse out.
// Latency: none (wires only).
// Backpressure: valid/ready on both the matrix and the result side.
interface matinv2_if #(
  parameter int DATA_WIDTH  = 16,
  parameter int MATRIX_SIZE = 4
);
  logic                              in_valid;
  logic                              in_ready;
  logic [DATA_WIDTH*MATRIX_SIZE-1:0] a;
  logic                              out_valid;
  logic                              out_ready;
  logic [DATA_WIDTH*MATRIX_SIZE-1:0] inv;
  logic                              singular;

  // producer/consumer side
  modport master (
    output in_valid, a, out_ready,
    input  in_ready, out_valid, inv, singular
  );

  // inverse block side
  modport slave (
    input  in_valid, a, out_ready,
    output in_ready, out_valid, inv, singular
  );
endinterface

// File: rtl/matinv2.sv
// Sequential 2x2 fixed-point inverse: det, bit-serial reciprocal, then four scaled elements.
// Latency: 2*DATA_WIDTH+6 cycles accept-to-result (2 cycles for a singular matrix).
// Backpressure: one matrix in flight; in_ready low while busy, result held until out_ready.
module matinv2 #(
  parameter int DATA_WIDTH  = 16,
  parameter int BIN_POS     = 8,
  parameter int MATRIX_SIZE = 4
) (
  input logic       clk,
  input logic       rst,
  matinv2_if.slave  bus
);
  localparam int DW = DATA_WIDTH;
  localparam int QW = 2 * DATA_WIDTH;
  localparam int CW = $clog2(QW);
  localparam logic [CW-1:0] CNT_LAST = CW'(QW - 1);
  // quotient step at which the single set bit of the 2^(2*BIN_POS) dividend enters
  localparam logic [CW-1:0] CNT_ONE  = CW'(QW - 1 - 2 * BIN_POS);
  localparam logic [DW-1:0] Q_MAX_DW = {1'b0, {(DW-1){1'b1}}};
  localparam logic [QW-1:0] Q_MAX    = {{(DW+1){1'b0}}, {(DW-1){1'b1}}};

  typedef enum logic [2:0] {IDLE, DET, DIV, SCALE, DONE} state_t;

  // fixed-point multiply: full-width product, arithmetic shift, wrap to DW bits
  function automatic logic signed [DW-1:0] mul(input logic signed [DW-1:0] x,
                                                input logic signed [DW-1:0] y);
    logic signed [QW-1:0] xe;
    logic signed [QW-1:0] ye;
    logic signed [QW-1:0] p;
    xe = {{DW{x[DW-1]}}, x};
    ye = {{DW{y[DW-1]}}, y};
    p  = (xe * ye) >>> BIN_POS;
    return DW'(p);
  endfunction

  state_t                state, state_nxt;
  logic signed [DW-1:0]  m     [MATRIX_SIZE];
  logic signed [DW-1:0]  acc   [3];
  logic                  sgn;
  logic [DW:0]           absdet;
  logic [DW-1:0]         rem;
  logic [QW-1:0]         quo;
  logic [CW-1:0]         cnt;
  logic [1:0]            idx;
  logic signed [DW-1:0]  recip;
  logic [DW*MATRIX_SIZE-1:0] inv_r;
  logic                  sing_r;

  logic signed [DW-1:0]  det;
  logic signed [DW:0]    det_ext;
  logic [DW:0]           det_abs;
  logic                  det_zero;
  logic                  div_bit;
  logic [DW:0]           rem_sh;
  logic [DW:0]           rem_sub;
  logic [DW:0]           rem_nx;
  logic                  ge;
  logic [QW-1:0]         q_nx;
  logic [DW-1:0]         q_sat;
  logic signed [DW-1:0]  recip_nx;
  logic signed [DW-1:0]  op;
  logic signed [DW-1:0]  prod;

  // determinant and its DW+1-bit magnitude (so the most negative det stays exact)
  always_comb begin
    det      = mul(m[0], m[3]) - mul(m[1], m[2]);
    det_ext  = {det[DW-1], det};
    det_abs  = det[DW-1] ? -det_ext : det_ext;
    det_zero = (det == '0);
  end

  // one restoring-division step; the remainder always fits DW bits since it is below |det|
  always_comb begin
    div_bit  = (cnt == CNT_ONE);
    rem_sh   = {rem, div_bit};
    ge       = (rem_sh >= absdet);
    rem_sub  = rem_sh - absdet;
    rem_nx   = ge ? rem_sub : rem_sh;
    q_nx     = QW'({quo, ge});
    q_sat    = (q_nx > Q_MAX) ? Q_MAX_DW : DW'(q_nx);
    recip_nx = sgn ? -q_sat : q_sat;
  end

  // single shared scaling multiplier, operand selected by element index
  always_comb begin
    op = m[3];
    case (idx)
      2'd0:    op = m[3];
      2'd1:    op = -m[1];
      2'd2:    op = -m[2];
      default: op = m[0];
    endcase
    prod = mul(op, recip);
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next-state and handshake outputs
  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) state_nxt = DET;
      end
      DET:   state_nxt = det_zero ? DONE : DIV;
      DIV:   if (cnt == CNT_LAST) state_nxt = SCALE;
      SCALE: if (idx == 2'd3) state_nxt = DONE;
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // datapath: capture, divide, scale; results only update on the way into DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < MATRIX_SIZE; k++) m[k] <= '0;
      for (int k = 0; k < 3; k++) acc[k] <= '0;
      sgn    <= 1'b0;
      absdet <= '0;
      rem    <= '0;
      quo    <= '0;
      cnt    <= '0;
      idx    <= '0;
      recip  <= '0;
      inv_r  <= '0;
      sing_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid)
            for (int k = 0; k < MATRIX_SIZE; k++) m[k] <= bus.a[k*DW +: DW];
        end
        DET: begin
          if (det_zero) begin
            inv_r  <= '0;
            sing_r <= 1'b1;
          end else begin
            sgn    <= det[DW-1];
            absdet <= det_abs;
            rem    <= '0;
            quo    <= '0;
            cnt    <= '0;
          end
        end
        DIV: begin
          rem <= DW'(rem_nx);
          quo <= q_nx;
          cnt <= cnt + CW'(1);
          if (cnt == CNT_LAST) begin
            recip <= recip_nx;
            idx   <= '0;
          end
        end
        SCALE: begin
          idx <= idx + 2'd1;
          case (idx)
            2'd0: acc[0] <= prod;
            2'd1: acc[1] <= prod;
            2'd2: acc[2] <= prod;
            default: begin
              inv_r  <= {prod, acc[2], acc[1], acc[0]};
              sing_r <= 1'b0;
            end
          endcase
        end
        default: ;
      endcase
    end
  end

  assign bus.inv      = inv_r;
  assign bus.singular = sing_r;
endmodule

// File: tb/tb_matinv2.sv
// Directed bench for matinv2 at DATA_WIDTH=16, BIN_POS=8.
// Latency n means out_valid is seen just before the n-th rising edge after the accept edge.
// Outputs are sampled on the falling edge; inputs are driven on the falling edge.
module tb_matinv2;
  localparam int DW = 16;
  localparam int MS = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  matinv2_if #(.DATA_WIDTH(DW), .MATRIX_SIZE(MS)) bus ();

  matinv2 #(.DATA_WIDTH(DW), .BIN_POS(8), .MATRIX_SIZE(MS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] pack(input logic [15:0] e0, input logic [15:0] e1,
                                       input logic [15:0] e2, input logic [15:0] e3);
    return {e3, e2, e1, e0};
  endfunction

  // drive one matrix, return at the falling edge where out_valid is first seen; lat=-1 on timeout
  task automatic do_txn(input logic [63:0] mat, output int lat);
    int w;
    lat = -1;
    @(negedge clk);
    w = 0;
    while (bus.in_ready !== 1'b1 && w < 100) begin
      @(negedge clk);
      w++;
    end
    bus.a        = mat;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  // complete the result handshake from a falling edge where out_valid is high
  task automatic finish_txn();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
    checks++; if (bus.inv !== 64'h0) begin errors++; $display("FAIL reset_inv got %h exp 0", bus.inv); end
    checks++; if (bus.singular !== 1'b0) begin errors++; $display("FAIL reset_singular got %b exp 0", bus.singular); end
    rst = 1'b0;
  endtask

  task automatic test_identity();
    int lat;
    logic [63:0] exp_inv;
    exp_inv = pack(16'h0100, 16'h0000, 16'h0000, 16'h0100);
    do_txn(pack(16'h0100, 16'h0000, 16'h0000, 16'h0100), lat);
    checks++; if (lat !== 38) begin errors++; $display("FAIL identity_latency got %0d exp 38", lat); end
    checks++; if (bus.inv !== exp_inv) begin errors++; $display("FAIL identity_inv got %h exp %h", bus.inv, exp_inv); end
    checks++; if (bus.singular !== 1'b0) begin errors++; $display("FAIL identity_singular got %b exp 0", bus.singular); end
    finish_txn();
  endtask

  task automatic test_diag();
    int lat;
    logic [63:0] exp_inv;
    exp_inv = pack(16'h0080, 16'h0000, 16'h0000, 16'h0040);
    do_txn(pack(16'h0200, 16'h0000, 16'h0000, 16'h0400), lat);
    checks++; if (bus.inv !== exp_inv) begin errors++; $display("FAIL diag_inv got %h exp %h", bus.inv, exp_inv); end
    finish_txn();
  endtask

  task automatic test_swap();
    int lat;
    logic [63:0] exp_inv;
    exp_inv = pack(16'h0000, 16'h0100, 16'h0100, 16'h0000);
    do_txn(pack(16'h0000, 16'h0100, 16'h0100, 16'h0000), lat);
    checks++; if (bus.inv !== exp_inv) begin errors++; $display("FAIL swap_inv got %h exp %h", bus.inv, exp_inv); end
    checks++; if (bus.singular !== 1'b0) begin errors++; $display("FAIL swap_singular got %b exp 0", bus.singular); end
    finish_txn();
  endtask

  task automatic test_singular();
    int lat;
    do_txn(pack(16'h0100, 16'h0200, 16'h0200, 16'h0400), lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL singular_latency got %0d exp 2", lat); end
    checks++; if (bus.singular !== 1'b1) begin errors++; $display("FAIL singular_flag got %b exp 1", bus.singular); end
    checks++; if (bus.inv !== 64'h0) begin errors++; $display("FAIL singular_inv got %h exp 0", bus.inv); end
    finish_txn();
  endtask

  // det = 1 LSB: reciprocal 2^16 saturates to 0x7FFF, inv = 0x10*0x7FFF>>8 = 0x07FF
  task automatic test_saturate();
    int lat;
    logic [63:0] exp_inv;
    exp_inv = pack(16'h07FF, 16'h0000, 16'h0000, 16'h07FF);
    do_txn(pack(16'h0010, 16'h0000, 16'h0000, 16'h0010), lat);
    checks++; if (bus.inv !== exp_inv) begin errors++; $display("FAIL saturate_inv got %h exp %h", bus.inv, exp_inv); end
    checks++; if (bus.singular !== 1'b0) begin errors++; $display("FAIL saturate_singular got %b exp 0", bus.singular); end
    finish_txn();
  endtask

  // det = -2^15: |det| = 0x8000, recip = -2, inv0 = 0x100*-2>>8 = -2, inv3 = -32768*-2>>8 = 0x100
  task automatic test_min_det();
    int lat;
    logic [63:0] exp_inv;
    exp_inv = pack(16'hFFFE, 16'h0000, 16'h0000, 16'h0100);
    do_txn(pack(16'h8000, 16'h0000, 16'h0000, 16'h0100), lat);
    checks++; if (bus.inv !== exp_inv) begin errors++; $display("FAIL min_det_inv got %h exp %h", bus.inv, exp_inv); end
    finish_txn();
  endtask

  task automatic test_backpressure();
    logic [63:0] exp_inv;
    int bad_stable;
    int bad_ready;
    int w;
    exp_inv = pack(16'h0080, 16'h0000, 16'h0000, 16'h0040);
    @(negedge clk);
    bus.a        = pack(16'h0200, 16'h0000, 16'h0000, 16'h0400);
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    // pulse in_valid with a different matrix while busy; it must be ignored
    bus.a = pack(16'h0000, 16'h0100, 16'h0100, 16'h0000);
    for (int p = 0; p < 3; p++) begin
      repeat (4) @(negedge clk);
      bus.in_valid = 1'b1;
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
    w = 0;
    while (bus.out_valid !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_done got %b exp 1", bus.out_valid); end
    checks++; if (bus.inv !== exp_inv) begin errors++; $display("FAIL bp_inv got %h exp %h", bus.inv, exp_inv); end
    bad_stable = 0;
    bad_ready  = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.inv !== exp_inv || bus.out_valid !== 1'b1) bad_stable++;
      if (bus.in_ready !== 1'b0) bad_ready++;
    end
    checks++; if (bad_stable !== 0) begin errors++; $display("FAIL bp_hold_stable got %0d bad cycles exp 0", bad_stable); end
    checks++; if (bad_ready !== 0) begin errors++; $display("FAIL bp_in_ready_low got %0d bad cycles exp 0", bad_ready); end
    finish_txn();
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_after_out_valid got %b exp 0", bus.out_valid); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_after_in_ready got %b exp 1", bus.in_ready); end
    checks++; if (bus.inv !== exp_inv) begin errors++; $display("FAIL bp_after_inv_kept got %h exp %h", bus.inv, exp_inv); end
  endtask

  // out_ready held high throughout: early ready has no effect, results still arrive on time
  task automatic test_back_to_back();
    int lat;
    logic [63:0] exp1;
    logic [63:0] exp2;
    exp1 = pack(16'h0000, 16'h0100, 16'h0100, 16'h0000);
    exp2 = pack(16'h0080, 16'h0000, 16'h0000, 16'h0040);
    bus.out_ready = 1'b1;
    do_txn(pack(16'h0000, 16'h0100, 16'h0100, 16'h0000), lat);
    checks++; if (lat !== 38) begin errors++; $display("FAIL b2b_lat1 got %0d exp 38", lat); end
    checks++; if (bus.inv !== exp1) begin errors++; $display("FAIL b2b_inv1 got %h exp %h", bus.inv, exp1); end
    do_txn(pack(16'h0200, 16'h0000, 16'h0000, 16'h0400), lat);
    checks++; if (lat !== 38) begin errors++; $display("FAIL b2b_lat2 got %0d exp 38", lat); end
    checks++; if (bus.inv !== exp2) begin errors++; $display("FAIL b2b_inv2 got %h exp %h", bus.inv, exp2); end
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_div();
    int lat;
    int seen;
    logic [63:0] exp_inv;
    exp_inv = pack(16'h0100, 16'h0000, 16'h0000, 16'h0100);
    @(negedge clk);
    bus.a        = pack(16'h0100, 16'h0000, 16'h0000, 16'h0100);
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    // edge 1 enters DIV; the reset is sampled at the end of DIV cycle 5
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_div_in_ready got %b exp 1", bus.in_ready); end
    checks++; if (bus.inv !== 64'h0) begin errors++; $display("FAIL rst_div_inv got %h exp 0", bus.inv); end
    seen = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rst_div_no_out_valid got %0d cycles exp 0", seen); end
    do_txn(pack(16'h0100, 16'h0000, 16'h0000, 16'h0100), lat);
    checks++; if (lat !== 38) begin errors++; $display("FAIL rst_div_relat got %0d exp 38", lat); end
    checks++; if (bus.inv !== exp_inv) begin errors++; $display("FAIL rst_div_reinv got %h exp %h", bus.inv, exp_inv); end
    finish_txn();
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    test_reset();
    test_identity();
    test_diag();
    test_swap();
    test_singular();
    test_saturate();
    test_min_det();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_div();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
